vis_stream_ctrl: RTL

Readout scheduler between the correlator's visibility bus and an 8-bit AXI-Stream byte sink (UART, USB bulk IN, or loopback FIFO). On each frame-ready pulse it emits a framed packet: a 4-byte header, then each visibility as 8 bytes (real then imaginary, MSB first), closed by `tlast`. It pulls words from the correlator with a valid/ready handshake only when it can forward them. This decouples correlator frame timing from the host link rate.

---
 rtl/vis_stream_ctrl_if.sv | 21 ++
 rtl/vis_stream_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vis_stream_ctrl_if.sv
// vis_stream_ctrl_if: correlator word bus plus AXI-Stream byte sink seen by vis_stream_ctrl.
// master is the controller side, slave is the correlator/sink side.
interface vis_stream_ctrl_if;
    logic [31:0] revis;
    logic [31:0] imvis;
    logic        valid;
    logic        ready;
    logic        last;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [7:0]  tdata;
    modport master (
        input  revis, imvis, valid, last, tready,
        output ready, tvalid, tlast, tdata
    );
    modport slave (
        output revis, imvis, valid, last, tready,
        input  ready, tvalid, tlast, tdata
    );
endinterface

// File: rtl/vis_stream_ctrl.sv
// vis_stream_ctrl: frames correlator visibilities into header + 8-byte-per-word AXI-Stream packets.
// Define VIS_STREAM_CHECKSUM_EN to append an XOR checksum byte carrying tlast.
module vis_stream_ctrl #(
    parameter int         COUNT = 16,
    parameter logic [7:0] SYNC0 = 8'hA5,
    parameter logic [7:0] SYNC1 = 8'h5A
) (
    input  logic                      bus_clock,
    input  logic                      bus_rst_n,
    input  logic                      vis_frame_i,
    vis_stream_ctrl_if.master         sig,
    output logic                      busy_o,
    output logic [7:0]                dropped_o
);
    localparam int WW = $clog2(COUNT + 1);
    localparam logic [WW-1:0] CNT = WW'(COUNT);
    localparam logic [2:0] IDLE = 3'd0, HDR = 3'd1, LOAD = 3'd2, DATA = 3'd3, CSUM = 3'd4;
    logic [2:0]    state;
    logic [2:0]    idx;
    logic [15:0]   seq;
    logic [WW-1:0] wcnt;
    logic [55:0]   sh;
    logic          fend;
    logic [7:0]    csum;
    logic          xfer;
    assign xfer = sig.tvalid && sig.tready;
    always_ff @(posedge bus_clock) begin
        if (!bus_rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            seq        <= 16'd0;
            wcnt       <= '0;
            sh         <= 56'd0;
            fend       <= 1'b0;
            csum       <= 8'd0;
            sig.ready  <= 1'b0;
            sig.tvalid <= 1'b0;
            sig.tlast  <= 1'b0;
            sig.tdata  <= 8'd0;
            busy_o     <= 1'b0;
            dropped_o  <= 8'd0;
        end else begin
            if (vis_frame_i && state != IDLE && dropped_o != 8'hFF)
                dropped_o <= dropped_o + 1'b1;
            if (xfer) begin
                csum <= csum ^ sig.tdata;
                idx  <= idx + 1'b1;
            end
            case (state)
                IDLE: if (vis_frame_i) begin
                    state      <= HDR;
                    busy_o     <= 1'b1;
                    sig.tvalid <= 1'b1;
                    sig.tdata  <= SYNC0;
                    idx        <= 3'd0;
                    wcnt       <= '0;
                    csum       <= 8'd0;
                end
                HDR: if (xfer) begin
                    if (idx == 3'd3) begin
                        state      <= LOAD;
                        sig.tvalid <= 1'b0;
                        sig.ready  <= 1'b1;
                    end else
                        sig.tdata <= idx == 3'd0 ? SYNC1 : idx == 3'd1 ? seq[15:8] : seq[7:0];
                end
                LOAD: if (sig.valid && sig.ready) begin
                    state      <= DATA;
                    sig.ready  <= 1'b0;
                    sig.tvalid <= 1'b1;
                    sig.tdata  <= sig.revis[31:24];
                    sh         <= {sig.revis[23:0], sig.imvis};
                    idx        <= 3'd0;
                    wcnt       <= wcnt + 1'b1;
                    fend       <= sig.last || (wcnt + 1'b1 == CNT);
                end
                DATA: if (xfer) begin
                    if (idx == 3'd7) begin
                        if (!fend) begin
                            state      <= LOAD;
                            sig.tvalid <= 1'b0;
                            sig.ready  <= 1'b1;
                        end
`ifdef VIS_STREAM_CHECKSUM_EN
                        else begin
                            // byte 7 is transferring now, so fold it in directly
                            state     <= CSUM;
                            sig.tdata <= csum ^ sig.tdata;
                            sig.tlast <= 1'b1;
                        end
`else
                        else begin
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                            sig.tvalid <= 1'b0;
                            sig.tlast  <= 1'b0;
                            seq        <= seq + 1'b1;
                        end
`endif
                    end else begin
                        sig.tdata <= sh[55:48];
                        sh        <= {sh[47:0], 8'd0};
`ifndef VIS_STREAM_CHECKSUM_EN
                        sig.tlast <= idx == 3'd6 && fend;
`endif
                    end
                end
`ifdef VIS_STREAM_CHECKSUM_EN
                CSUM: if (xfer) begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    sig.tvalid <= 1'b0;
                    sig.tlast  <= 1'b0;
                    seq        <= seq + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
